// File: rtl/sync_pkg.sv
// ---------------------------------------------------------------------------
// sync_pkg
// Shared definitions for the sync_debounce_bank input conditioning block.
//   SYNC_MIN_STAGES : smallest legal synchronizer depth
//   clog2()         : constant-evaluable ceiling log2, used to size the
//                     debounce counter
//   edge_pair_t     : per-channel {rise, fall} pulse pair
// ---------------------------------------------------------------------------
package sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_pair_t;

endpackage

// File: rtl/sync_debounce_ch.sv
// ---------------------------------------------------------------------------
// sync_debounce_ch
// One channel of the debounce bank: STAGES-deep metastability chain, a
// saturating-free debounce counter, the accepted (stable) level and
// registered one-cycle rise/fall pulses.
//
// Optional feature macro: SYNC_DEBOUNCE_STICKY_EN adds a sticky rise flag
// (set by a rise pulse, cleared by clr; set wins).
//
// Ports:
//   clk        in   system clock, rising edge
//   R          in   synchronous active-high reset
//   sig        in   asynchronous raw input
//   clr        in   sticky clear          (SYNC_DEBOUNCE_STICKY_EN only)
//   sticky     out  sticky rise flag      (SYNC_DEBOUNCE_STICKY_EN only)
//   sig_sync   out  last synchronizer stage (undebounced)
//   sig_stable out  debounced level
//   rise       out  one-cycle pulse on sig_stable 0->1
//   fall       out  one-cycle pulse on sig_stable 1->0
// ---------------------------------------------------------------------------
module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int STAGES          = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic R,
    input  logic sig,
`ifdef SYNC_DEBOUNCE_STICKY_EN
    input  logic clr,
    output logic sticky,
`endif
    output logic sig_sync,
    output logic sig_stable,
    output logic rise,
    output logic fall
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_debounce_ch: STAGES must be at least 2");
    end

    // Terminal count: the last cycle of disagreement before acceptance.
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0] chain_q, chain_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stable_q, stable_d;
    edge_pair_t        edges_q, edges_d;

    always_comb begin
        chain_d  = {chain_q[STAGES-2:0], sig};
        cnt_d    = '0;
        stable_d = stable_q;
        edges_d  = '0;
        if (chain_q[STAGES-1] != stable_q) begin
            if (cnt_q == TERM_CNT) begin
                // Disagreement held long enough: accept and pulse once.
                stable_d     = chain_q[STAGES-1];
                edges_d.rise = chain_q[STAGES-1];
                edges_d.fall = ~chain_q[STAGES-1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Agreement (glitch returned) leaves cnt_d at its cleared default.
    end

    always_ff @(posedge clk) begin
        if (R) begin
            chain_q  <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            edges_q  <= '0;
        end else begin
            chain_q  <= chain_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            edges_q  <= edges_d;
        end
    end

    assign sig_sync   = chain_q[STAGES-1];
    assign sig_stable = stable_q;
    assign rise       = edges_q.rise;
    assign fall       = edges_q.fall;

`ifdef SYNC_DEBOUNCE_STICKY_EN
    logic sticky_q, sticky_d;

    // Keyed off the next-state rise so the flag appears with the pulse;
    // a coincident clear loses to the set.
    always_comb begin
        sticky_d = sticky_q;
        if (edges_d.rise) begin
            sticky_d = 1'b1;
        end else if (clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`endif

endmodule

// File: rtl/sync_debounce_bank.sv
// ---------------------------------------------------------------------------
// sync_debounce_bank
// Multi-channel input conditioner: per channel a metastability chain,
// a counter-based debouncer and one-cycle rise/fall pulse generators.
// Channels are independent; this level only slices the buses.
//
// Optional feature macro: SYNC_DEBOUNCE_STICKY_EN adds clr/sticky buses.
//
// Ports:
//   clk        in   system clock, rising edge
//   R          in   synchronous active-high reset
//   sig        in   [CHANNELS] asynchronous raw inputs
//   clr        in   [CHANNELS] sticky clears (SYNC_DEBOUNCE_STICKY_EN only)
//   sticky     out  [CHANNELS] sticky rise flags (SYNC_DEBOUNCE_STICKY_EN only)
//   sig_sync   out  [CHANNELS] synchronized, undebounced levels
//   sig_stable out  [CHANNELS] debounced levels
//   rise       out  [CHANNELS] one-cycle rising-edge pulses
//   fall       out  [CHANNELS] one-cycle falling-edge pulses
// ---------------------------------------------------------------------------
module sync_debounce_bank
    import sync_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int STAGES          = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                R,
    input  logic [CHANNELS-1:0] sig,
`ifdef SYNC_DEBOUNCE_STICKY_EN
    input  logic [CHANNELS-1:0] clr,
    output logic [CHANNELS-1:0] sticky,
`endif
    output logic [CHANNELS-1:0] sig_sync,
    output logic [CHANNELS-1:0] sig_stable,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        sync_debounce_ch #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk        (clk),
            .R          (R),
            .sig        (sig[gi]),
`ifdef SYNC_DEBOUNCE_STICKY_EN
            .clr        (clr[gi]),
            .sticky     (sticky[gi]),
`endif
            .sig_sync   (sig_sync[gi]),
            .sig_stable (sig_stable[gi]),
            .rise       (rise[gi]),
            .fall       (fall[gi])
        );
    end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_sync_debounce_bank
// Directed phases followed by random stimulus. The reference model keeps a
// history of raw samples per channel: sig_sync is the sample taken STAGES-1
// edges ago, and the stable level flips when every one of the DEBOUNCE_CYCLES
// synchronized samples preceding the edge disagrees with it.
// ---------------------------------------------------------------------------
module tb_sync_debounce_bank;

    localparam int CH   = 4;
    localparam int STG  = 2;
    localparam int DB   = 4;
    localparam int HLEN = STG + DB;

    logic          clk;
    logic          R;
    logic [CH-1:0] sig;
    logic [CH-1:0] sig_sync;
    logic [CH-1:0] sig_stable;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
`ifdef SYNC_DEBOUNCE_STICKY_EN
    logic [CH-1:0] clr;
    logic [CH-1:0] sticky;
    logic [CH-1:0] sticky_m;
`endif

    sync_debounce_bank #(
        .CHANNELS        (CH),
        .STAGES          (STG),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .R          (R),
        .sig        (sig),
`ifdef SYNC_DEBOUNCE_STICKY_EN
        .clr        (clr),
        .sticky     (sticky),
`endif
        .sig_sync   (sig_sync),
        .sig_stable (sig_stable),
        .rise       (rise),
        .fall       (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    // hist[ch][k] = raw sample taken k edges ago (k=0: this edge)
    logic [HLEN-1:0] hist [CH];
    logic [CH-1:0]   sync_m, stable_m, rise_m, fall_m;

    task automatic model_update();
        for (int ch = 0; ch < CH; ch++) begin
            if (R) begin
                hist[ch]     = '0;
                sync_m[ch]   = 1'b0;
                stable_m[ch] = 1'b0;
                rise_m[ch]   = 1'b0;
                fall_m[ch]   = 1'b0;
            end else begin
                logic all_diff;
                hist[ch]   = {hist[ch][HLEN-2:0], sig[ch]};
                sync_m[ch] = hist[ch][STG-1];
                all_diff   = 1'b1;
                for (int k = STG; k < HLEN; k++) begin
                    if (hist[ch][k] == stable_m[ch]) all_diff = 1'b0;
                end
                rise_m[ch] = all_diff & ~stable_m[ch];
                fall_m[ch] = all_diff &  stable_m[ch];
                if (all_diff) stable_m[ch] = ~stable_m[ch];
            end
`ifdef SYNC_DEBOUNCE_STICKY_EN
            if (R)                sticky_m[ch] = 1'b0;
            else if (rise_m[ch])  sticky_m[ch] = 1'b1;
            else if (clr[ch])     sticky_m[ch] = 1'b0;
`endif
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert (sig_sync === sync_m) else begin
            failures++;
            $error("FAIL sig_sync cyc=%0d got=%b exp=%b", cyc, sig_sync, sync_m);
        end
        checks++;
        assert (sig_stable === stable_m) else begin
            failures++;
            $error("FAIL sig_stable cyc=%0d got=%b exp=%b", cyc, sig_stable, stable_m);
        end
        checks++;
        assert (rise === rise_m) else begin
            failures++;
            $error("FAIL rise cyc=%0d got=%b exp=%b", cyc, rise, rise_m);
        end
        checks++;
        assert (fall === fall_m) else begin
            failures++;
            $error("FAIL fall cyc=%0d got=%b exp=%b", cyc, fall, fall_m);
        end
`ifdef SYNC_DEBOUNCE_STICKY_EN
        checks++;
        assert (sticky === sticky_m) else begin
            failures++;
            $error("FAIL sticky cyc=%0d got=%b exp=%b", cyc, sticky, sticky_m);
        end
`endif
    endtask

    // One clock edge: drive inputs, update the model at the edge, sample #1 later.
    task automatic step(input logic [CH-1:0] s, input logic r);
        sig = s;
        R   = r;
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        check_outputs();
        rise_cnt += $countones(rise_m);
        fall_cnt += $countones(fall_m);
        $display("cyc=%0d R=%b sig=%b sync=%b stable=%b rise=%b fall=%b",
                 cyc, r, s, sig_sync, sig_stable, rise, fall);
    endtask

    logic [CH-1:0] cur;

    initial begin
        sig = '0;
        R   = 1'b1;
`ifdef SYNC_DEBOUNCE_STICKY_EN
        clr = '0;
`endif
        for (int i = 0; i < CH; i++) hist[i] = '0;
        sync_m = '0; stable_m = '0; rise_m = '0; fall_m = '0;
`ifdef SYNC_DEBOUNCE_STICKY_EN
        sticky_m = '0;
`endif

        // Reset, then quiet inputs.
        for (int i = 0; i < 3; i++) step('0, 1'b1);
        for (int i = 0; i < 20; i++) step('0, 1'b0);

        // Channel 0 rises and holds.
        cur = 4'b0001;
        for (int i = 0; i < 10; i++) step(cur, 1'b0);

        // Channel 1 high for exactly 3 sampling edges: must be rejected.
        for (int i = 0; i < 3; i++) step(cur | 4'b0010, 1'b0);
        for (int i = 0; i < 8; i++) step(cur, 1'b0);

        // Channels 2 and 3 together up, 10 cycles later together down.
        cur = 4'b1101;
        for (int i = 0; i < 10; i++) step(cur, 1'b0);
        cur = 4'b0001;
        for (int i = 0; i < 10; i++) step(cur, 1'b0);

        // Drop channel 0, re-raise, reset at count 2, then hold.
        for (int i = 0; i < 10; i++) step('0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        for (int i = 0; i < 10; i++) step(4'b0001, 1'b0);

`ifdef SYNC_DEBOUNCE_STICKY_EN
        // Clear held across the next rise: set must win.
        clr = 4'b0001;
        for (int i = 0; i < 8; i++) step('0, 1'b0);
        for (int i = 0; i < 8; i++) step(4'b0001, 1'b0);
        clr = '0;
        step(4'b0001, 1'b0);
        clr = 4'b0001;
        step(4'b0001, 1'b0);
        clr = '0;
        step(4'b0001, 1'b0);
`endif

        // Random stimulus: frequent flips give glitches, holds give accepts.
        cur = '0;
        for (int n = 0; n < 600; n++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if ($urandom_range(0, 5) == 0) cur[ch] = ~cur[ch];
            end
`ifdef SYNC_DEBOUNCE_STICKY_EN
            clr = CH'($urandom_range(0, 15)) & CH'($urandom_range(0, 15));
`endif
            step(cur, ($urandom_range(0, 149) == 0));
        end

        // Sanity on the stimulus itself: edges must have occurred.
        checks++;
        assert (rise_cnt > 8 && fall_cnt > 8) else begin
            failures++;
            $error("FAIL edge_activity got rise=%0d fall=%0d exp >8 each", rise_cnt, fall_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
